// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the RV32 multi-cycle controller: FSM states, opcodes,
// ALUOp / ALUControl codes and datapath mux selects.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU control decode from ALUOp, funct3, funct7 (instr[30]) and op[5].
module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_BRANCH: begin
        // beq/bne/blt compare via subtraction; other funct3 codes fall back to ADD
        if (funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b100)
          alu_control_o = ALU_SUB;
      end
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  if ({op5_i, funct7_i} == 2'b11) alu_control_o = ALU_SUB;
          3'b001:  alu_control_o = ALU_SHL;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = ALU_SHR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle FSM sequencer for lw/sw/R/I/branch sharing one ALU and one memory port.
// Write enables are gated by rst_n so nothing is written while reset is held.
module riscv_multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter bit SYNC_MEM = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               Zero,
  input  logic               sign_flag,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [2:0]         ALUControl,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_o
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       mem_rdy, taken;
  logic       pc_write, ir_write, mem_write, reg_write, illegal, done;

  assign mem_rdy = SYNC_MEM ? 1'b1 : mem_ready;
  assign state_o = STATE_W'(state_q);

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = sign_flag;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    done      = 1'b0;
    AdrSrc    = ADR_PC;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch target into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = ADR_RESULT;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = ADR_RESULT;
        mem_write = 1'b1;
        if (mem_rdy) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        alu_op   = ALUOP_BRANCH;
        pc_write = taken;
        done     = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      default:   ImmSrc = IMM_I;
    endcase
  end

  assign PCWrite    = rst_n & pc_write;
  assign IRWrite    = rst_n & ir_write;
  assign MemWrite   = rst_n & mem_write;
  assign RegWrite   = rst_n & reg_write;
  assign illegal_op = rst_n & illegal;
  assign instr_done = rst_n & done;

  riscv_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7_i      (funct7),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

endmodule
